// File: rtl/lsu_sched_pkg.sv
// Shared constants, FSM encoding and instruction field layout for the LSU issue scheduler.
package lsu_sched_pkg;

  localparam int unsigned PTR_W = 5;
  localparam int unsigned REG_W = 5;
  localparam int unsigned DEP_W = 4;
  localparam int unsigned OP_W  = 32;
  localparam int unsigned IMM_W = 12;

  localparam logic [DEP_W-1:0] NO_DEP = 4'hF;

  // Field positions inside the stored instruction word
  localparam int unsigned RS1_LSB     = 0;
  localparam int unsigned RS2_LSB     = 5;
  localparam int unsigned DEP_L_LSB   = 10;
  localparam int unsigned DEP_R_LSB   = 14;
  localparam int unsigned USE_IMM_BIT = 18;
  localparam int unsigned IMM_LSB     = 19;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_ISSUE = 2'd3
  } sched_state_e;

  function automatic logic [OP_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(OP_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/lsu_issue_sched_if.sv
// Dispatch, operand-read, operand-response, execute and status signals of the LSU issue scheduler.
interface lsu_issue_sched_if
  import lsu_sched_pkg::*;
#(
  parameter int unsigned INSN_W = 113
);

  logic              enq_valid;
  logic              enq_ready;
  logic [INSN_W-1:0] enq_insn;
  logic              flush;

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [REG_W-1:0]  rd_rs1;
  logic [REG_W-1:0]  rd_rs2;
  logic [DEP_W-1:0]  rd_dep_l;
  logic [DEP_W-1:0]  rd_dep_r;
  logic              rd_src_l;
  logic              rd_src_r;

  logic              opl_valid;
  logic [OP_W-1:0]   opl_data;
  logic              opr_valid;
  logic [OP_W-1:0]   opr_data;

  logic              exe_valid;
  logic              exe_ready;
  logic [INSN_W-1:0] exe_insn;
  logic [OP_W-1:0]   exe_opl;
  logic [OP_W-1:0]   exe_opr;

  logic              q_empty;
  logic [PTR_W-1:0]  q_count;

  modport slave (
    input  enq_valid, enq_insn, flush, rd_req_ready,
           opl_valid, opl_data, opr_valid, opr_data, exe_ready,
    output enq_ready, rd_req_valid, rd_rs1, rd_rs2, rd_dep_l, rd_dep_r,
           rd_src_l, rd_src_r, exe_valid, exe_insn, exe_opl, exe_opr,
           q_empty, q_count
  );

  modport master (
    output enq_valid, enq_insn, flush, rd_req_ready,
           opl_valid, opl_data, opr_valid, opr_data, exe_ready,
    input  enq_ready, rd_req_valid, rd_rs1, rd_rs2, rd_dep_l, rd_dep_r,
           rd_src_l, rd_src_r, exe_valid, exe_insn, exe_opl, exe_opr,
           q_empty, q_count
  );

endinterface

// File: rtl/lsu_sched_queue.sv
// Instruction FIFO: wrap-bit pointers (mod 2*DEPTH), storage indexed by the low pointer bits.
module lsu_sched_queue
  import lsu_sched_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned INSN_W = 113
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [INSN_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [INSN_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [PTR_W-1:0]  count_o
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(2 * DEPTH - 1);

  logic [INSN_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic              do_push;

  // Flush beats a same-cycle push
  assign do_push = push_i & ~flush_i;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = (wr_q + PTR_W'(1)) & PTR_MASK;
      if (pop_i)   rd_d = (rd_q + PTR_W'(1)) & PTR_MASK;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[IDX_W-1:0]] <= push_data_i;
  end

  assign count_o = (wr_q - rd_q) & PTR_MASK;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == PTR_W'(DEPTH));
  assign head_o  = mem_q[rd_q[IDX_W-1:0]];

endmodule

// File: rtl/lsu_issue_sched.sv
// LSU issue scheduler: pops queued instructions, requests operands, collects them and issues to execute.
module lsu_issue_sched
  import lsu_sched_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned INSN_W = 113
) (
  input  logic             clk,
  input  logic             rstn,
  lsu_issue_sched_if.slave sched_if
);

  sched_state_e      state_q, state_d;
  logic [INSN_W-1:0] insn_q;
  logic [INSN_W-1:0] head;
  logic [OP_W-1:0]   opl_q, opr_q;
  logic              have_l_q, have_r_q;
  logic              src_l_q, src_r_q;
  logic              rd_req_valid_q, exe_valid_q;
  logic              q_empty, q_full, push, pop, load, cap_l, cap_r;
  logic [PTR_W-1:0]  q_count;
  logic              head_use_imm;

  assign push         = sched_if.enq_valid & ~q_full;
  assign head_use_imm = head[USE_IMM_BIT];

  lsu_sched_queue #(
    .DEPTH  (DEPTH),
    .INSN_W (INSN_W)
  ) u_queue (
    .clk         (clk),
    .rstn        (rstn),
    .flush_i     (sched_if.flush),
    .push_i      (push),
    .push_data_i (sched_if.enq_insn),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (q_empty),
    .full_o      (q_full),
    .count_o     (q_count)
  );

  // Next state; popping the head and loading the issue register happen on the same edge
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    cap_l   = 1'b0;
    cap_r   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!q_empty) begin
          load    = 1'b1;
          pop     = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (sched_if.rd_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        cap_l = sched_if.opl_valid & ~have_l_q;
        cap_r = sched_if.opr_valid & ~have_r_q;
        if ((have_l_q || sched_if.opl_valid) && (have_r_q || sched_if.opr_valid)) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sched_if.exe_ready) begin
          if (!q_empty) begin
            load    = 1'b1;
            pop     = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (sched_if.flush) begin
      state_d = S_IDLE;
      pop     = 1'b0;
      load    = 1'b0;
      cap_l   = 1'b0;
      cap_r   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Issue register and operand collection; an immediate pre-fills the right operand
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      insn_q         <= '0;
      opl_q          <= '0;
      opr_q          <= '0;
      have_l_q       <= 1'b0;
      have_r_q       <= 1'b0;
      src_l_q        <= 1'b0;
      src_r_q        <= 1'b0;
      rd_req_valid_q <= 1'b0;
      exe_valid_q    <= 1'b0;
    end else if (sched_if.flush) begin
      insn_q         <= '0;
      opl_q          <= '0;
      opr_q          <= '0;
      have_l_q       <= 1'b0;
      have_r_q       <= 1'b0;
      src_l_q        <= 1'b0;
      src_r_q        <= 1'b0;
      rd_req_valid_q <= 1'b0;
      exe_valid_q    <= 1'b0;
    end else begin
      rd_req_valid_q <= (state_d == S_REQ);
      exe_valid_q    <= (state_d == S_ISSUE);
      if (load) begin
        insn_q   <= head;
        opl_q    <= '0;
        have_l_q <= 1'b0;
        have_r_q <= head_use_imm;
        opr_q    <= head_use_imm ? sext_imm(head[IMM_LSB +: IMM_W]) : '0;
        src_l_q  <= (head[DEP_L_LSB +: DEP_W] != NO_DEP);
        src_r_q  <= (head[DEP_R_LSB +: DEP_W] != NO_DEP);
      end
      if (cap_l) begin
        opl_q    <= sched_if.opl_data;
        have_l_q <= 1'b1;
      end
      if (cap_r) begin
        opr_q    <= sched_if.opr_data;
        have_r_q <= 1'b1;
      end
    end
  end

  assign sched_if.enq_ready    = ~q_full;
  assign sched_if.q_empty      = q_empty;
  assign sched_if.q_count      = q_count;
  assign sched_if.rd_req_valid = rd_req_valid_q;
  assign sched_if.rd_rs1       = insn_q[RS1_LSB +: REG_W];
  assign sched_if.rd_rs2       = insn_q[RS2_LSB +: REG_W];
  assign sched_if.rd_dep_l     = insn_q[DEP_L_LSB +: DEP_W];
  assign sched_if.rd_dep_r     = insn_q[DEP_R_LSB +: DEP_W];
  assign sched_if.rd_src_l     = src_l_q;
  assign sched_if.rd_src_r     = src_r_q;
  assign sched_if.exe_valid    = exe_valid_q;
  assign sched_if.exe_insn     = insn_q;
  assign sched_if.exe_opl      = opl_q;
  assign sched_if.exe_opr      = opr_q;

endmodule

// File: tb/tb_lsu_issue_sched.sv
// Randomised bench for lsu_issue_sched with a transaction-level scoreboard of the issue stream.
module tb_lsu_issue_sched;
  import lsu_sched_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned INSN_W = 113;

  logic clk;
  logic rstn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_issue_sched_if #(.INSN_W(INSN_W)) bus ();

  lsu_issue_sched #(
    .DEPTH  (DEPTH),
    .INSN_W (INSN_W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sched_if (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: accepted-but-not-requested instructions, plus the one being collected/issued
  logic [INSN_W-1:0] pend_q[$];
  logic [INSN_W-1:0] cur_insn;
  logic [31:0]       exp_opl, exp_opr;
  int                phase;      // 0 none in flight, 1 awaiting operands, 2 issuing
  bit                have_l, have_r;
  int                accepted, issued;
  bit                flush_prev;

  function automatic logic [31:0] imm_value(input logic [11:0] imm);
    int v;
    v = $signed(imm);
    return 32'(v);
  endfunction

  function automatic logic [INSN_W-1:0] make_insn(input logic [3:0] dl, input logic [3:0] dr,
                                                  input bit ui, input logic [11:0] imm);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[DEP_L_LSB +: 4]  = dl;
    r[DEP_R_LSB +: 4]  = dr;
    r[USE_IMM_BIT]     = ui;
    r[IMM_LSB +: 12]   = imm;
    return r[INSN_W-1:0];
  endfunction

  function automatic logic [INSN_W-1:0] rand_insn();
    logic [3:0] dl, dr;
    dl = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
    dr = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
    return make_insn(dl, dr, $urandom_range(0, 2) == 0, 12'($urandom));
  endfunction

  // Check current outputs against the scoreboard, account for the coming edge, then advance
  task automatic step_cycle();
    logic [INSN_W-1:0] f;
    if (flush_prev) begin
      check_eq("flush_rd_req_low", bus.rd_req_valid, 1'b0);
      check_eq("flush_exe_low", bus.exe_valid, 1'b0);
      check_eq("flush_count", bus.q_count, 5'd0);
      check_eq("flush_empty", bus.q_empty, 1'b1);
    end
    check_eq("exe_valid_timing", bus.exe_valid, phase == 2);
    if (phase != 0) check_eq("rd_req_while_busy", bus.rd_req_valid, 1'b0);
    if (phase == 2 && bus.exe_valid) begin
      check_eq("exe_insn", bus.exe_insn, cur_insn);
      check_eq("exe_opl", bus.exe_opl, exp_opl);
      check_eq("exe_opr", bus.exe_opr, exp_opr);
    end
    if (bus.rd_req_valid && phase == 0) begin
      if (pend_q.size() == 0) begin
        check_eq("rd_req_spurious", 1'b1, 1'b0);
      end else begin
        f = pend_q[0];
        check_eq("rd_rs1", bus.rd_rs1, f[RS1_LSB +: REG_W]);
        check_eq("rd_rs2", bus.rd_rs2, f[RS2_LSB +: REG_W]);
        check_eq("rd_dep_l", bus.rd_dep_l, f[DEP_L_LSB +: DEP_W]);
        check_eq("rd_dep_r", bus.rd_dep_r, f[DEP_R_LSB +: DEP_W]);
        check_eq("rd_src_l", bus.rd_src_l, f[DEP_L_LSB +: DEP_W] != 4'hF);
        check_eq("rd_src_r", bus.rd_src_r, f[DEP_R_LSB +: DEP_W] != 4'hF);
      end
    end
    flush_prev = bus.flush;
    if (bus.flush) begin
      pend_q.delete();
      phase = 0;
    end else begin
      if (phase == 1) begin
        if (bus.opl_valid && !have_l) begin exp_opl = bus.opl_data; have_l = 1'b1; end
        if (bus.opr_valid && !have_r) begin exp_opr = bus.opr_data; have_r = 1'b1; end
        if (have_l && have_r) phase = 2;
      end else if (phase == 2 && bus.exe_valid && bus.exe_ready) begin
        phase = 0;
        issued++;
      end
      if (phase == 0 && bus.rd_req_valid && bus.rd_req_ready && pend_q.size() > 0) begin
        f        = pend_q.pop_front();
        cur_insn = f;
        have_l   = 1'b0;
        exp_opl  = '0;
        have_r   = f[USE_IMM_BIT];
        exp_opr  = have_r ? imm_value(f[IMM_LSB +: IMM_W]) : 32'd0;
        phase    = 1;
      end
      if (bus.enq_valid && bus.enq_ready) begin
        pend_q.push_back(bus.enq_insn);
        accepted++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    bus.enq_valid    = 1'b0;
    bus.flush        = 1'b0;
    bus.rd_req_ready = 1'b1;
    bus.opl_valid    = 1'b1;
    bus.opr_valid    = 1'b1;
    bus.exe_ready    = 1'b1;
    n = 0;
    while ((pend_q.size() != 0 || phase != 0) && n < max_cycles) begin
      bus.opl_data = $urandom;
      bus.opr_data = $urandom;
      step_cycle();
      n++;
    end
    check_eq("drain_in_budget", n < max_cycles, 1'b1);
    check_eq("drain_empty", bus.q_empty, 1'b1);
    check_eq("drain_count", bus.q_count, 5'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [INSN_W-1:0] insn;
    int base, n;
    phase = 0; have_l = 0; have_r = 0; accepted = 0; issued = 0; flush_prev = 0;
    exp_opl = '0; exp_opr = '0; cur_insn = '0;
    bus.enq_valid = 0; bus.enq_insn = '0; bus.flush = 0; bus.rd_req_ready = 0;
    bus.opl_valid = 0; bus.opl_data = '0; bus.opr_valid = 0; bus.opr_data = '0;
    bus.exe_ready = 0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_enq_ready", bus.enq_ready, 1'b1);
    check_eq("rst_q_empty", bus.q_empty, 1'b1);
    check_eq("rst_q_count", bus.q_count, 5'd0);
    check_eq("rst_rd_req_valid", bus.rd_req_valid, 1'b0);
    check_eq("rst_exe_valid", bus.exe_valid, 1'b0);
    check_eq("rst_exe_insn", bus.exe_insn, '0);
    check_eq("rst_exe_ops", {bus.exe_opl, bus.exe_opr}, '0);
    check_eq("rst_rd_fields", {bus.rd_rs1, bus.rd_rs2, bus.rd_dep_l, bus.rd_dep_r,
                               bus.rd_src_l, bus.rd_src_r}, '0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Minimum latency, bypass/GRF source select, and a stalled execute stage
    insn = make_insn(4'hF, 4'h3, 1'b0, 12'h000);
    bus.enq_valid = 1; bus.enq_insn = insn; bus.rd_req_ready = 1;
    bus.opl_valid = 1; bus.opl_data = 32'h11111111;
    bus.opr_valid = 1; bus.opr_data = 32'h22222222; bus.exe_ready = 0;
    step_cycle();
    bus.enq_valid = 0;
    check_eq("lat_e0_no_req", bus.rd_req_valid, 1'b0);
    check_eq("lat_e0_count", bus.q_count, 5'd1);
    step_cycle();
    check_eq("lat_e1_req", bus.rd_req_valid, 1'b1);
    check_eq("lat_e1_src_l", bus.rd_src_l, 1'b0);
    check_eq("lat_e1_src_r", bus.rd_src_r, 1'b1);
    check_eq("lat_e1_count", bus.q_count, 5'd0);
    step_cycle();
    check_eq("lat_e2_wait", bus.rd_req_valid, 1'b0);
    step_cycle();
    check_eq("lat_e3_exe", bus.exe_valid, 1'b1);
    check_eq("lat_e3_opl", bus.exe_opl, 32'h11111111);
    check_eq("lat_e3_opr", bus.exe_opr, 32'h22222222);
    check_eq("lat_e3_insn", bus.exe_insn, insn);
    bus.opl_data = 32'hDEADBEEF; bus.opr_data = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      bus.opl_valid = i[0];
      step_cycle();
      check_eq("stall_opl_stable", bus.exe_opl, 32'h11111111);
      check_eq("stall_insn_stable", bus.exe_insn, insn);
    end
    bus.exe_ready = 1;
    step_cycle();
    check_eq("stall_release", bus.exe_valid, 1'b0);

    // Immediate right operand: only opl_valid is supplied
    insn = make_insn(4'h2, 4'h5, 1'b1, 12'hFFC);
    bus.enq_valid = 1; bus.enq_insn = insn;
    bus.opl_valid = 1; bus.opl_data = 32'h00000AB3; bus.opr_valid = 0;
    bus.exe_ready = 0;
    step_cycle();
    bus.enq_valid = 0;
    n = 0;
    while (!bus.exe_valid && n < 10) begin step_cycle(); n++; end
    check_eq("imm_exe_seen", bus.exe_valid, 1'b1);
    check_eq("imm_exe_opr", bus.exe_opr, 32'hFFFFFFFC);
    check_eq("imm_exe_opl", bus.exe_opl, 32'h00000AB3);
    drain(50);

    // Fill the queue behind a stalled execute stage, then flush with a competing enqueue
    bus.exe_ready = 0; bus.rd_req_ready = 1; bus.opl_valid = 1; bus.opr_valid = 1;
    base = accepted;
    for (int i = 0; i < 20; i++) begin
      bus.enq_valid = 1; bus.enq_insn = rand_insn();
      step_cycle();
    end
    check_eq("full_accepted", accepted - base, DEPTH + 1);
    check_eq("full_count", bus.q_count, 5'd16);
    check_eq("full_enq_ready", bus.enq_ready, 1'b0);
    bus.flush = 1;
    step_cycle();
    bus.flush = 0; bus.enq_valid = 0;
    check_eq("full_flush_count", bus.q_count, 5'd0);
    check_eq("full_flush_ready", bus.enq_ready, 1'b1);
    step_cycle();

    // Flush while awaiting operands with three entries queued
    bus.rd_req_ready = 0; bus.opl_valid = 0; bus.opr_valid = 0; bus.exe_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bus.enq_valid = 1; bus.enq_insn = rand_insn();
      step_cycle();
    end
    bus.enq_valid = 0;
    check_eq("wflush_queued", bus.q_count, 5'd3);
    check_eq("wflush_req", bus.rd_req_valid, 1'b1);
    bus.rd_req_ready = 1;
    step_cycle();
    bus.rd_req_ready = 0;
    check_eq("wflush_in_wait", bus.rd_req_valid, 1'b0);
    bus.flush = 1; bus.enq_valid = 1; bus.enq_insn = rand_insn(); bus.opl_valid = 1;
    step_cycle();
    bus.flush = 0; bus.enq_valid = 0;
    check_eq("wflush_count", bus.q_count, 5'd0);
    check_eq("wflush_exe", bus.exe_valid, 1'b0);
    bus.opr_valid = 1; bus.exe_ready = 1;
    repeat (3) step_cycle();
    check_eq("wflush_stays_idle", {bus.rd_req_valid, bus.exe_valid}, 2'b00);

    // Back-to-back stream of 40 instructions; pointers wrap past 32
    base = accepted;
    n = issued;
    for (int c = 0; c < 400 && accepted - base < 40; c++) begin
      bus.enq_valid = 1; bus.enq_insn = rand_insn();
      bus.rd_req_ready = 1; bus.opl_valid = 1; bus.opr_valid = 1; bus.exe_ready = 1;
      bus.opl_data = $urandom; bus.opr_data = $urandom;
      step_cycle();
    end
    check_eq("stream_accepted", accepted - base, 40);
    drain(300);
    check_eq("stream_issued", issued - n, 40);

    // Random handshakes with occasional flushes
    for (int c = 0; c < 800; c++) begin
      bus.enq_valid    = $urandom_range(0, 1) == 1;
      bus.enq_insn     = rand_insn();
      bus.rd_req_ready = $urandom_range(0, 3) != 0;
      bus.opl_valid    = $urandom_range(0, 2) == 0;
      bus.opl_data     = $urandom;
      bus.opr_valid    = $urandom_range(0, 2) == 0;
      bus.opr_data     = $urandom;
      bus.exe_ready    = $urandom_range(0, 2) != 0;
      bus.flush        = $urandom_range(0, 99) == 0;
      step_cycle();
    end
    bus.flush = 0;
    drain(400);
    check_eq("final_exe_idle", bus.exe_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
